// File: rtl/bus_dma_if.sv
// Initiator-side bus bundle for bus_dma: the DMA drives request/address/data,
// the arbiter and responder return grant, ready and read data.
interface bus_dma_if #(
  parameter int ADDR_W = 16
) ();
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [7:0]        bus_dout;
  logic [7:0]        bus_din;
  logic              bus_rdy;

  modport master (
    output bus_req, bus_addr, bus_we, bus_dout,
    input  bus_grant, bus_din, bus_rdy
  );

  modport slave (
    input  bus_req, bus_addr, bus_we, bus_dout,
    output bus_grant, bus_din, bus_rdy
  );
endinterface

// File: rtl/bus_dma.sv
// Single-channel byte DMA: memory-to-memory copy or constant fill, paced by a
// divided bus clock (bus_phase) and gated by a bus grant and responder ready.
module bus_dma #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_phase,
  input  logic       cfg_write,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [7:0] cfg_rdata,
  output logic       busy,
  output logic       done,
  bus_dma_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state_q;
  logic              phase_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        fill_q;
  logic              fill_mode_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              bus_req_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              bus_we_q;
  logic [7:0]        bus_dout_q;

  logic [ADDR_W-1:0] src_d;
  logic [ADDR_W-1:0] dst_d;
  logic [LEN_W-1:0]  len_d;
  logic              phase_rise_s;
  logic              ctl_wr_s;
  logic              start_s;
  logic              abort_s;
  logic              clear_s;
  logic              reg_wr_s;
  logic [15:0]       src_w_s;
  logic [15:0]       dst_w_s;
  logic [15:0]       len_w_s;

  // Replace the low or high byte of a 16-bit register image.
  function automatic logic [15:0] put_byte(input logic [15:0] old, input logic hi,
                                           input logic [7:0] b);
    return hi ? {b, old[7:0]} : {old[15:8], b};
  endfunction

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_we   = bus_we_q;
  assign bus.bus_dout = bus_dout_q;

  // Control decode, bus-cycle boundary detect and post-write counter values.
  always_comb begin
    phase_rise_s = bus_phase & ~phase_q;
    ctl_wr_s     = cfg_write & (cfg_addr == 3'd7);
    abort_s      = ctl_wr_s & cfg_data[2];
    start_s      = ctl_wr_s & cfg_data[0] & ~cfg_data[2];
    clear_s      = ctl_wr_s & cfg_data[3];
    reg_wr_s     = cfg_write & (cfg_addr != 3'd7) & ~busy_q;
    src_d        = fill_mode_q ? src_q : (src_q + ADDR_W'(1'b1));
    dst_d        = dst_q + ADDR_W'(1'b1);
    len_d        = len_q - LEN_W'(1'b1);
  end

  // Register readback: working counters, fill byte and status.
  always_comb begin
    src_w_s = 16'(src_q);
    dst_w_s = 16'(dst_q);
    len_w_s = 16'(len_q);
    case (cfg_addr)
      3'd0:    cfg_rdata = src_w_s[7:0];
      3'd1:    cfg_rdata = src_w_s[15:8];
      3'd2:    cfg_rdata = dst_w_s[7:0];
      3'd3:    cfg_rdata = dst_w_s[15:8];
      3'd4:    cfg_rdata = len_w_s[7:0];
      3'd5:    cfg_rdata = len_w_s[15:8];
      3'd6:    cfg_rdata = fill_q;
      3'd7:    cfg_rdata = {5'b00000, aborted_q, done_q, busy_q};
      default: cfg_rdata = 8'h00;
    endcase
  end

  // Configuration registers, transfer FSM and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      src_q       <= {ADDR_W{1'b0}};
      dst_q       <= {ADDR_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      fill_q      <= 8'h00;
      fill_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_we_q    <= 1'b0;
      bus_dout_q  <= 8'h00;
    end else begin
      phase_q <= bus_phase;
      if (reg_wr_s) begin
        case (cfg_addr)
          3'd0:    src_q  <= ADDR_W'(put_byte(src_w_s, 1'b0, cfg_data));
          3'd1:    src_q  <= ADDR_W'(put_byte(src_w_s, 1'b1, cfg_data));
          3'd2:    dst_q  <= ADDR_W'(put_byte(dst_w_s, 1'b0, cfg_data));
          3'd3:    dst_q  <= ADDR_W'(put_byte(dst_w_s, 1'b1, cfg_data));
          3'd4:    len_q  <= LEN_W'(put_byte(len_w_s, 1'b0, cfg_data));
          3'd5:    len_q  <= LEN_W'(put_byte(len_w_s, 1'b1, cfg_data));
          3'd6:    fill_q <= cfg_data;
          default: fill_q <= fill_q;
        endcase
      end
      if (clear_s) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (abort_s && busy_q) begin
        state_q   <= IDLE;
        bus_req_q <= 1'b0;
        bus_we_q  <= 1'b0;
        aborted_q <= 1'b1;
        done_q    <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_s) begin
              done_q      <= 1'b0;
              aborted_q   <= 1'b0;
              busy_q      <= 1'b1;
              fill_mode_q <= cfg_data[1];
              if (len_q == {LEN_W{1'b0}}) begin
                state_q <= FINISH;
              end else begin
                state_q   <= REQ;
                bus_req_q <= 1'b1;
              end
            end
          end
          REQ: begin
            if (phase_rise_s && bus.bus_grant) begin
              if (fill_mode_q) begin
                state_q    <= WRITE;
                bus_addr_q <= dst_q;
                bus_we_q   <= 1'b1;
                bus_dout_q <= fill_q;
              end else begin
                state_q    <= READ;
                bus_addr_q <= src_q;
                bus_we_q   <= 1'b0;
              end
            end
          end
          READ: begin
            // bus_dout_q doubles as the captured-byte register for the write.
            if (phase_rise_s && bus.bus_rdy) begin
              state_q    <= WRITE;
              bus_addr_q <= dst_q;
              bus_we_q   <= 1'b1;
              bus_dout_q <= bus.bus_din;
            end
          end
          WRITE: begin
            if (phase_rise_s && bus.bus_rdy) begin
              src_q <= src_d;
              dst_q <= dst_d;
              len_q <= len_d;
              if (len_d == {LEN_W{1'b0}}) begin
                state_q   <= FINISH;
                bus_req_q <= 1'b0;
                bus_we_q  <= 1'b0;
              end else if (!bus.bus_grant) begin
                state_q  <= REQ;
                bus_we_q <= 1'b0;
              end else if (fill_mode_q) begin
                state_q    <= WRITE;
                bus_addr_q <= dst_d;
                bus_we_q   <= 1'b1;
                bus_dout_q <= fill_q;
              end else begin
                state_q    <= READ;
                bus_addr_q <= src_d;
                bus_we_q   <= 1'b0;
              end
            end
          end
          FINISH: begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a memory responder plus a write scoreboard that
// checks every completed bus write against the expected address/data queue.
module tb_bus_dma;
  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       bus_phase = 1'b0;
  logic       cfg_write = 1'b0;
  logic [2:0] cfg_addr  = 3'd0;
  logic [7:0] cfg_data  = 8'h00;
  logic [7:0] cfg_rdata;
  logic       busy;
  logic       done;
  logic       grant     = 1'b1;
  logic       rdy       = 1'b1;

  logic [7:0]  mem [0:65535];
  logic [23:0] sb [$];
  int n_tests = 0;
  int n_fail = 0;
  int pcnt = 0;
  int rise_cnt = 0;
  int wr_count = 0;
  int c000_cnt = 0;
  int last_rise = 0;
  logic rise_next = 1'b0;

  bus_dma_if #(.ADDR_W(16)) bif ();

  bus_dma #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .bus_phase(bus_phase),
    .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_rdata(cfg_rdata), .busy(busy), .done(done), .bus(bif)
  );

  assign bif.bus_grant = grant;
  assign bif.bus_rdy   = rdy;
  assign bif.bus_din   = rdy ? mem[bif.bus_addr] : 8'hEE;

  always #5 clk = ~clk;

  // bus_phase: 2 clk low, 2 clk high; rise_next flags the coming phase_rise edge
  always @(negedge clk) begin
    pcnt      <= pcnt + 1;
    bus_phase <= ((pcnt % 4) >= 2);
    rise_next <= ((pcnt % 4) == 2);
    if ((pcnt % 4) == 2) rise_cnt <= rise_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a write completes at a phase_rise with bus_we=1 and rdy=1
  always @(negedge clk) begin
    logic [23:0] e;
    #1;
    if (reset && rise_next) begin
      if (bif.bus_we && rdy) begin
        wr_count++;
        mem[bif.bus_addr] = bif.bus_dout;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %04h data %02h expected none",
                   bif.bus_addr, bif.bus_dout);
        end else begin
          e = sb.pop_front();
          check("bus_write", 32'({bif.bus_addr, bif.bus_dout}), 32'(e));
        end
      end
      if (bif.bus_req && !bif.bus_we && bif.bus_addr == 16'hC000) c000_cnt++;
    end
  end

  task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); #2;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_write = 1'b1;
    @(posedge clk); #1;
    cfg_write = 1'b0;
    last_rise = rise_cnt;
  endtask

  task automatic expect_reg(input string name, input logic [2:0] a, input logic [7:0] e);
    @(negedge clk); #2;
    cfg_addr = a;
    #1;
    check(name, 32'(cfg_rdata), 32'(e));
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                       input logic [7:0] f);
    cfg_wr(3'd0, s[7:0]);  cfg_wr(3'd1, s[15:8]);
    cfg_wr(3'd2, d[7:0]);  cfg_wr(3'd3, d[15:8]);
    cfg_wr(3'd4, n[7:0]);  cfg_wr(3'd5, n[15:8]);
    cfg_wr(3'd6, f);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 2000) begin
      @(negedge clk); #2;
      k++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_rises(input int n);
    int r = rise_cnt;
    int k = 0;
    while (rise_cnt < r + n && k < 1000) begin
      @(negedge clk); #2;
      k++;
    end
    if (rise_cnt < r + n) begin
      n_tests++; n_fail++;
      $display("FAIL rise_wait: got %0d rises expected %0d", rise_cnt - r, n);
    end
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_count < n && k < 2000) begin
      @(negedge clk); #2;
      k++;
    end
    if (wr_count < n) begin
      n_tests++; n_fail++;
      $display("FAIL write_wait: got %0d writes expected %0d", wr_count, n);
    end
  endtask

  initial begin
    int r0;
    int base;
    int bad;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hE000] = 8'h11; mem[16'hE001] = 8'h22; mem[16'hE002] = 8'h33;
    mem[16'hE010] = 8'h5A; mem[16'hE011] = 8'hC3; mem[16'hC000] = 8'h7E;

    // reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_req", 32'(bif.bus_req), 32'd0);
    check("rst_bus_we", 32'(bif.bus_we), 32'd0);
    check("rst_bus_addr", 32'(bif.bus_addr), 32'd0);
    check("rst_bus_dout", 32'(bif.bus_dout), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    expect_reg("rst_status", 3'd7, 8'h00);
    expect_reg("rst_len_lo", 3'd4, 8'h00);

    // copy 3 bytes E000 -> 0200: 6 bus cycles after the grant rise
    setup(16'hE000, 16'h0200, 16'd3, 8'h00);
    sb.push_back({16'h0200, 8'h11});
    sb.push_back({16'h0201, 8'h22});
    sb.push_back({16'h0202, 8'h33});
    cfg_wr(3'd7, 8'h01);
    r0 = last_rise;
    check("copy_busy", 32'(busy), 32'd1);
    check("copy_bus_req", 32'(bif.bus_req), 32'd1);
    wait_done("copy");
    check("copy_rises", 32'(rise_cnt - r0), 32'd7);
    check("copy_ram", 32'({mem[16'h0200], mem[16'h0201], mem[16'h0202]}), 32'h112233);
    check("copy_sb_empty", 32'(sb.size()), 32'd0);
    expect_reg("copy_status", 3'd7, 8'h02);

    // fill 4 bytes from FFFE wrapping to 0001
    setup(16'h0000, 16'hFFFE, 16'd4, 8'hA5);
    sb.push_back({16'hFFFE, 8'hA5});
    sb.push_back({16'hFFFF, 8'hA5});
    sb.push_back({16'h0000, 8'hA5});
    sb.push_back({16'h0001, 8'hA5});
    cfg_wr(3'd7, 8'h03);
    r0 = last_rise;
    check("fill_done_cleared", 32'(done), 32'd0);
    wait_done("fill");
    check("fill_rises", 32'(rise_cnt - r0), 32'd5);
    check("fill_sb_empty", 32'(sb.size()), 32'd0);
    expect_reg("fill_dst_lo", 3'd2, 8'h02);
    expect_reg("fill_dst_hi", 3'd3, 8'h00);
    expect_reg("fill_len_lo", 3'd4, 8'h00);

    // zero length: busy one clk, done, never requests the bus
    setup(16'h1234, 16'h5678, 16'd0, 8'h00);
    cfg_wr(3'd7, 8'h01);
    check("len0_busy", 32'(busy), 32'd1);
    check("len0_req", 32'(bif.bus_req), 32'd0);
    @(posedge clk); #1;
    check("len0_busy_end", 32'(busy), 32'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_req_end", 32'(bif.bus_req), 32'd0);

    // responder not ready for two rises while reading C000
    setup(16'hC000, 16'h0400, 16'd1, 8'h00);
    rdy = 1'b0;
    c000_cnt = 0;
    sb.push_back({16'h0400, 8'h7E});
    cfg_wr(3'd7, 8'h01);
    wait_rises(3);
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done("stall");
    check("stall_addr_cycles", 32'(c000_cnt), 32'd3);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // grant removed after the first write, then restored
    setup(16'hE010, 16'h0300, 16'd2, 8'h00);
    sb.push_back({16'h0300, 8'h5A});
    sb.push_back({16'h0301, 8'hC3});
    base = wr_count;
    cfg_wr(3'd7, 8'h01);
    wait_wr(base + 1);
    grant = 1'b0;
    bad = 0;
    repeat (16) begin
      @(negedge clk); #2;
      if (bif.bus_we || !bif.bus_req) bad++;
    end
    check("nogrant_quiet", 32'(bad), 32'd0);
    check("nogrant_writes", 32'(wr_count), 32'(base + 1));
    expect_reg("nogrant_src_lo", 3'd0, 8'h11);
    expect_reg("nogrant_len_lo", 3'd4, 8'h01);
    grant = 1'b1;
    wait_done("regrant");
    check("regrant_sb_empty", 32'(sb.size()), 32'd0);
    check("regrant_ram", 32'({mem[16'h0300], mem[16'h0301]}), 32'h5AC3);

    // abort mid-copy (start bit set too: abort wins)
    setup(16'hE000, 16'h0500, 16'd8, 8'h00);
    sb.push_back({16'h0500, 8'h11});
    base = wr_count;
    cfg_wr(3'd7, 8'h01);
    wait_wr(base + 1);
    cfg_wr(3'd7, 8'h05);
    check("abort_req", 32'(bif.bus_req), 32'd0);
    check("abort_we", 32'(bif.bus_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    expect_reg("abort_status", 3'd7, 8'h04);
    wait_rises(3);
    @(posedge clk); #1;
    check("abort_writes", 32'(wr_count), 32'(base + 1));
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    cfg_wr(3'd7, 8'h05);
    check("idle_abort_beats_start", 32'(busy), 32'd0);
    cfg_wr(3'd7, 8'h08);
    expect_reg("clear_status", 3'd7, 8'h00);

    // reset in the middle of a fill
    setup(16'h0000, 16'h0600, 16'd5, 8'h3C);
    sb.push_back({16'h0600, 8'h3C});
    base = wr_count;
    cfg_wr(3'd7, 8'h03);
    wait_wr(base + 1);
    @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_req", 32'(bif.bus_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_we", 32'(bif.bus_we), 32'd0);
    check("midrst_addr", 32'(bif.bus_addr), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    wait_rises(3);
    @(posedge clk); #1;
    check("midrst_writes", 32'(wr_count), 32'(base + 1));
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    expect_reg("midrst_status", 3'd7, 8'h00);
    expect_reg("midrst_dst_lo", 3'd2, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
